serial_panel_scanner: RTL and testbench
=======================================

Name: serial_panel_scanner

Overview:
- Parametrised successor to the board's separate serial LED output driver and DIP/switch input parallelizer.
- One shared shift-clock engine runs both directions in the same frame:
  - shifts a parallel word out to a serial latch-register chain (LEDs or segments);
  - shifts the DIP/switch chain in.
- Word widths, shift-clock rate, bit order and free-run/on-demand mode are configurable.
- Sits between the top level and the panel shift-register chains, clocked from the system clock.

Parameters:
- OUT_W, 16: bits shifted out per frame.
- IN_W, 21: bits captured per frame (16 DIP + 5 switches).
- CLK_DIV, 4: i_CLK cycles per shift bit period; must be at least 2. HALF = CLK_DIV/2 (integer division).
- LSB_FIRST, 0: 1 shifts output bit 0 first; 0 shifts the MSB first.
- AUTO, 1: 1 rescans continuously; 0 runs one frame per i_Start.

Ports:
- i_CLK, in, 1: system clock; all logic on the rising edge.
- i_RESET_n, in, 1: asynchronous, active-low reset.
- i_OutData, in, OUT_W: word to display; sampled at frame start.
- i_Start, in, 1: frame request (AUTO=0 only).
- o_SerData, out, 1: serial data to the output chain.
- o_SerCLK, out, 1: shift clock shared by both chains.
- o_OutLatch, out, 1: output chain commit strobe.
- o_InLatch, out, 1: input chain parallel-load strobe.
- i_SerData, in, 1: serial data from the input chain.
- o_InData, out, IN_W: last completed captured word.
- o_InValid, out, 1: one-cycle pulse when o_InData updates.
- o_Busy, out, 1: high while a frame is in progress.

Behaviour:
- Reset (async, i_RESET_n=0):
  - FSM to IDLE; divider to 0.
  - All outputs 0, including o_InData.
  - Shadow and shift registers cleared.
  - Reset mid-frame aborts the frame: no o_OutLatch, no o_InValid.
- Frame length: N = max(OUT_W, IN_W).
- Tick: divider dc counts 0..CLK_DIV-1 while not IDLE and wraps. It is forced to 0 on IDLE->LOAD. A "period" means dc running 0..CLK_DIV-1 once.
- FSM IDLE -> LOAD -> SHIFT -> LATCH -> GAP -> IDLE.
- IDLE:
  - o_Busy=0.
  - AUTO=1: leave after exactly 1 cycle.
  - AUTO=0: leave on the cycle i_Start=1. i_Start is ignored in all other states.
- LOAD (1 period):
  - On entry, capture i_OutData into the shadow register; later i_OutData changes do not affect this frame.
  - o_InLatch=1 for the whole period; o_SerCLK=0.
- SHIFT (N periods, bit index k=0..N-1):
  - o_SerCLK = (dc >= HALF).
  - o_SerData is stable for the whole period.
  - The output bit stream is N-OUT_W zeros first, then the OUT_W data bits, so the data lands in the last OUT_W chain stages.
  - Data bit order: MSB first when LSB_FIRST=0; bit 0 first when LSB_FIRST=1.
  - i_SerData is sampled on the cycle dc==HALF (the o_SerCLK rising edge) and shifted into the LSB of the input shift register; older bits move toward the MSB.
- LATCH (1 period):
  - o_OutLatch=1; o_SerCLK=0; o_SerData=0.
  - On the last cycle, o_InData <= low IN_W bits of the input shift register, and o_InValid=1 on the following cycle only.
- GAP (1 period): all strobes 0; then IDLE.
- Frame duration:
  - (N+3)*CLK_DIV cycles from LOAD entry to IDLE.
  - AUTO=1 frame-start period is (N+3)*CLK_DIV+1.
- o_Busy=1 in every state except IDLE.
- Strobe and data outputs are registered.

Test Plan:
- Reset state: OUT_W=4, IN_W=4, CLK_DIV=2, AUTO=0; assert i_RESET_n=0 → all outputs 0. Release with no i_Start → o_Busy stays 0 for 100 cycles.
- Output, MSB first: i_OutData=4'b1011, pulse i_Start → o_InLatch high 2 cycles. SerData on the 4 SerCLK rising edges reads 1,0,1,1. o_OutLatch high 2 cycles. o_Busy high 14 cycles.
- Output, LSB first with padding: LSB_FIRST=1, OUT_W=4, IN_W=6, i_OutData=4'b0011 → edge sequence 0,0,1,1,0,0.
- Input capture: drive i_SerData so the 4 samples are 1,1,0,1 → o_InData=4'b1101, with o_InValid a 1-cycle pulse exactly 1 cycle after LATCH ends.
- Free run, defaults (AUTO=1, N=21, CLK_DIV=4) → o_InLatch rising edges exactly 97 cycles apart. Changing i_OutData mid-SHIFT alters only the next frame.
- Abort: assert i_RESET_n=0 at bit 2 of SHIFT → immediate all-zero outputs, no o_InValid, o_InData unchanged at 0. After release (AUTO=0), i_Start gives a clean full frame.

Source files
------------

// File: rtl/serial_panel_scanner.sv
// serial_panel_scanner: one shift-clock engine that drives the LED latch
// chain out and captures the DIP/switch chain in, in the same frame.
// Ports: i_CLK, i_RESET_n (async low); i_OutData/i_Start frame request;
// o_SerData/o_SerCLK/o_OutLatch to the output chain; o_InLatch/i_SerData
// with the input chain; o_InData/o_InValid captured word; o_Busy.
module serial_panel_scanner #(
  parameter int OUT_W     = 16,
  parameter int IN_W      = 21,
  parameter int CLK_DIV   = 4,
  parameter int LSB_FIRST = 0,
  parameter int AUTO      = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET_n,
  input  logic [OUT_W-1:0] i_OutData,
  input  logic             i_Start,
  output logic             o_SerData,
  output logic             o_SerCLK,
  output logic             o_OutLatch,
  output logic             o_InLatch,
  input  logic             i_SerData,
  output logic [IN_W-1:0]  o_InData,
  output logic             o_InValid,
  output logic             o_Busy
);

  localparam int N    = (OUT_W > IN_W) ? OUT_W : IN_W;
  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int KW   = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_GAP
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   dc, dc_n;
  logic [KW-1:0]   k, k_n;
  logic [N-1:0]    out_sr, out_sr_n;
  logic [IN_W-1:0] in_sr;
  logic [OUT_W-1:0] data_rev;
  logic [OUT_W-1:0] data_ord;
  logic            tick_end;
  logic            go;
  logic            frame_done;

  // Frame word is left-aligned as zero padding then data, and always
  // leaves from the top bit, so the data ends up in the far chain stages.
  assign data_rev   = {<<{i_OutData}};
  assign data_ord   = (LSB_FIRST != 0) ? data_rev : i_OutData;
  assign tick_end   = (dc == DW'(CLK_DIV - 1));
  assign go         = (AUTO != 0) || i_Start;
  assign frame_done = (state == S_LATCH) && tick_end;

  always_comb begin
    state_n  = state;
    dc_n     = dc;
    k_n      = k;
    out_sr_n = out_sr;
    if (state != S_IDLE) begin
      dc_n = tick_end ? '0 : dc + 1'b1;
    end
    unique case (state)
      S_IDLE: begin
        dc_n = '0;
        if (go) begin
          state_n  = S_LOAD;
          out_sr_n = N'(data_ord);
        end
      end
      S_LOAD: begin
        if (tick_end) begin
          state_n = S_SHIFT;
          k_n     = '0;
        end
      end
      S_SHIFT: begin
        if (tick_end) begin
          out_sr_n = out_sr << 1;
          if (k == KW'(N - 1)) begin
            state_n = S_LATCH;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (tick_end) state_n = S_GAP;
      end
      S_GAP: begin
        if (tick_end) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up
  // with the state they belong to.
  always_ff @(posedge i_CLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state      <= S_IDLE;
      dc         <= '0;
      k          <= '0;
      out_sr     <= '0;
      in_sr      <= '0;
      o_SerData  <= 1'b0;
      o_SerCLK   <= 1'b0;
      o_OutLatch <= 1'b0;
      o_InLatch  <= 1'b0;
      o_InData   <= '0;
      o_InValid  <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      state      <= state_n;
      dc         <= dc_n;
      k          <= k_n;
      out_sr     <= out_sr_n;
      if ((state == S_SHIFT) && (dc == DW'(HALF))) begin
        in_sr <= IN_W'({in_sr, i_SerData});
      end
      o_SerData  <= (state_n == S_SHIFT) && out_sr_n[N-1];
      o_SerCLK   <= (state_n == S_SHIFT) && (dc_n >= DW'(HALF));
      o_OutLatch <= (state_n == S_LATCH);
      o_InLatch  <= (state_n == S_LOAD);
      o_Busy     <= (state_n != S_IDLE);
      o_InValid  <= frame_done;
      if (frame_done) begin
        o_InData <= in_sr;
      end
    end
  end

endmodule

// File: tb/tb_serial_panel_scanner.sv
// tb_serial_panel_scanner: three scanner configurations, queued
// expectations popped by per-instance monitors on the negative edge.
module tb_serial_panel_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic fail_note(input string nm, input string why);
    n_chk++;
    n_err++;
    $display("FAIL %s: %s", nm, why);
  endtask

  // A: 4 out, 4 in, div 2, MSB first, on demand
  logic       a_rst_n = 1'b0, a_start = 1'b0, a_sdi = 1'b0;
  logic [3:0] a_data = '0;
  logic       a_sdo, a_sclk, a_olat, a_ilat, a_valid, a_busy;
  logic [3:0] a_indata;

  serial_panel_scanner #(.OUT_W(4), .IN_W(4), .CLK_DIV(2),
                         .LSB_FIRST(0), .AUTO(0)) dut_a (
    .i_CLK(clk), .i_RESET_n(a_rst_n), .i_OutData(a_data),
    .i_Start(a_start), .o_SerData(a_sdo), .o_SerCLK(a_sclk),
    .o_OutLatch(a_olat), .o_InLatch(a_ilat), .i_SerData(a_sdi),
    .o_InData(a_indata), .o_InValid(a_valid), .o_Busy(a_busy)
  );

  // B: 4 out, 6 in, div 2, LSB first, on demand
  logic       b_rst_n = 1'b0, b_start = 1'b0, b_sdi = 1'b0;
  logic [3:0] b_data = '0;
  logic       b_sdo, b_sclk, b_olat, b_ilat, b_valid, b_busy;
  logic [5:0] b_indata;

  serial_panel_scanner #(.OUT_W(4), .IN_W(6), .CLK_DIV(2),
                         .LSB_FIRST(1), .AUTO(0)) dut_b (
    .i_CLK(clk), .i_RESET_n(b_rst_n), .i_OutData(b_data),
    .i_Start(b_start), .o_SerData(b_sdo), .o_SerCLK(b_sclk),
    .o_OutLatch(b_olat), .o_InLatch(b_ilat), .i_SerData(b_sdi),
    .o_InData(b_indata), .o_InValid(b_valid), .o_Busy(b_busy)
  );

  // C: defaults, free running
  logic        c_rst_n = 1'b0, c_start = 1'b0, c_sdi = 1'b1;
  logic [15:0] c_data = 16'hA5C3;
  logic        c_sdo, c_sclk, c_olat, c_ilat, c_valid, c_busy;
  logic [20:0] c_indata;

  serial_panel_scanner dut_c (
    .i_CLK(clk), .i_RESET_n(c_rst_n), .i_OutData(c_data),
    .i_Start(c_start), .o_SerData(c_sdo), .o_SerCLK(c_sclk),
    .o_OutLatch(c_olat), .o_InLatch(c_ilat), .i_SerData(c_sdi),
    .o_InData(c_indata), .o_InValid(c_valid), .o_Busy(c_busy)
  );

  // scoreboard queues
  bit          a_exp_bits[$];
  bit          a_in_bits[$];
  logic [3:0]  a_exp_in[$];
  bit          b_exp_bits[$];
  bit          b_in_bits[$];
  logic [5:0]  b_exp_in[$];
  logic [20:0] c_exp[$];
  int a_vcnt = 0, b_vcnt = 0, c_vcnt = 0, c_fcnt = 0;

  // monitor A: data at each shift-clock rise, chain model feeds samples
  logic a_sclk_q = 1'b0, a_olat_q = 1'b0, a_valid_q = 1'b0;
  always @(negedge clk) begin
    if (a_sclk && !a_sclk_q) begin
      if (a_exp_bits.size() == 0) fail_note("a_ser_extra", "unexpected shift edge");
      else chk("a_ser_bit", 32'(a_sdo), 32'(a_exp_bits.pop_front()));
      if (a_in_bits.size() != 0) a_sdi = a_in_bits.pop_front();
      else a_sdi = 1'b0;
    end
    if (a_valid) begin
      a_vcnt++;
      chk("a_valid_after_latch", 32'(a_olat_q), 32'd1);
      chk("a_valid_latch_off", 32'(a_olat), 32'd0);
      chk("a_valid_width", 32'(a_valid_q), 32'd0);
      if (a_exp_in.size() == 0) fail_note("a_valid_extra", "unexpected o_InValid");
      else chk("a_indata", 32'(a_indata), 32'(a_exp_in.pop_front()));
    end
    a_sclk_q  = a_sclk;
    a_olat_q  = a_olat;
    a_valid_q = a_valid;
  end

  // monitor B
  logic b_sclk_q = 1'b0, b_olat_q = 1'b0, b_valid_q = 1'b0;
  always @(negedge clk) begin
    if (b_sclk && !b_sclk_q) begin
      if (b_exp_bits.size() == 0) fail_note("b_ser_extra", "unexpected shift edge");
      else chk("b_ser_bit", 32'(b_sdo), 32'(b_exp_bits.pop_front()));
      if (b_in_bits.size() != 0) b_sdi = b_in_bits.pop_front();
      else b_sdi = 1'b0;
    end
    if (b_valid) begin
      b_vcnt++;
      chk("b_valid_after_latch", 32'(b_olat_q), 32'd1);
      chk("b_valid_width", 32'(b_valid_q), 32'd0);
      if (b_exp_in.size() == 0) fail_note("b_valid_extra", "unexpected o_InValid");
      else chk("b_indata", 32'(b_indata), 32'(b_exp_in.pop_front()));
    end
    b_sclk_q  = b_sclk;
    b_olat_q  = b_olat;
    b_valid_q = b_valid;
  end

  // monitor C: collect a whole frame, compare at the commit strobe
  logic        c_sclk_q = 1'b0, c_olat_q = 1'b0, c_ilat_q = 1'b0;
  logic [20:0] c_col = '0;
  always @(negedge clk) begin
    if (c_ilat && !c_ilat_q) c_col = '0;
    if (c_sclk && !c_sclk_q) c_col = {c_col[19:0], c_sdo};
    if (c_olat && !c_olat_q) begin
      c_fcnt++;
      if (c_exp.size() == 0) fail_note("c_frame_extra", "unexpected frame");
      else chk("c_frame", 32'(c_col), 32'(c_exp.pop_front()));
    end
    if (c_valid) begin
      c_vcnt++;
      chk("c_indata", 32'(c_indata), 32'h1FFFFF);
    end
    c_sclk_q = c_sclk;
    c_olat_q = c_olat;
    c_ilat_q = c_ilat;
  end

  task automatic frame_a(input logic [3:0] d, input logic [3:0] exp_bits,
                         input logic [3:0] samp, input logic [3:0] exp_in);
    int busy_n, il, ol, v0;
    busy_n = 0; il = 0; ol = 0;
    v0 = a_vcnt;
    for (int i = 3; i >= 0; i--) a_exp_bits.push_back(exp_bits[i]);
    for (int i = 3; i >= 0; i--) a_in_bits.push_back(samp[i]);
    a_exp_in.push_back(exp_in);
    @(posedge clk); #1 a_data = d; a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0; a_data = ~d;
    repeat (24) begin
      @(negedge clk);
      if (a_busy) busy_n++;
      if (a_ilat) il++;
      if (a_olat) ol++;
    end
    chk("a_busy_cycles", busy_n, 14);
    chk("a_inlatch_cycles", il, 2);
    chk("a_outlatch_cycles", ol, 2);
    chk("a_bits_left", a_exp_bits.size(), 0);
    chk("a_valid_pulses", a_vcnt - v0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    c_exp.push_back({5'b0, 16'hA5C3});
    c_exp.push_back({5'b0, 16'hA5C3});
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_outs", 32'({a_busy, a_sclk, a_sdo, a_olat, a_ilat, a_valid}), 32'd0);
    chk("a_reset_indata", 32'(a_indata), 32'd0);
    chk("c_reset_outs", 32'({c_busy, c_sclk, c_sdo, c_olat, c_ilat, c_valid}), 32'd0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    c_rst_n = 1'b1;
    fork
      begin : branch_a
        int hi;
        hi = 0;
        repeat (100) begin
          @(negedge clk);
          if (a_busy) hi++;
        end
        chk("a_idle_no_start", hi, 0);
        frame_a(4'b1011, 4'b1011, 4'b1101, 4'b1101);
        frame_a(4'b0110, 4'b0110, 4'b0010, 4'b0010);
      end
      begin : branch_b
        int re, busy_n;
        logic prev, found;
        repeat (20) @(posedge clk);
        // aborted frame: two pad zeros then data bit 0
        b_exp_bits.push_back(1'b0);
        b_exp_bits.push_back(1'b0);
        b_exp_bits.push_back(1'b1);
        #1 b_data = 4'b0011; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        re = 0; prev = 1'b0; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
          @(negedge clk);
          if (b_sclk && !prev) re++;
          prev = b_sclk;
          if (re == 3) found = 1'b1;
        end
        if (!found) fail_note("b_abort_wait", "timed out before bit 2");
        #2 b_rst_n = 1'b0;
        #1;
        chk("b_abort_outs", 32'({b_busy, b_sclk, b_sdo, b_olat, b_ilat, b_valid}), 32'd0);
        chk("b_abort_indata", 32'(b_indata), 32'd0);
        chk("b_abort_bits", b_exp_bits.size(), 0);
        repeat (5) @(posedge clk);
        #1 b_rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("b_after_abort_busy", 32'(b_busy), 32'd0);
        chk("b_after_abort_indata", 32'(b_indata), 32'd0);
        chk("b_after_abort_valid", b_vcnt, 0);
        // clean frame: 0,0 pad then 0011 LSB first
        for (int i = 5; i >= 0; i--) b_exp_bits.push_back(bit'(6'b001100 >> i));
        for (int i = 5; i >= 0; i--) b_in_bits.push_back(bit'(6'b101101 >> i));
        b_exp_in.push_back(6'b101101);
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        busy_n = 0;
        repeat (30) begin
          @(negedge clk);
          if (b_busy) busy_n++;
        end
        chk("b_busy_cycles", busy_n, 18);
        chk("b_bits_left", b_exp_bits.size(), 0);
        chk("b_valid_pulses", b_vcnt, 1);
      end
      begin : branch_c
        int t[4];
        int ne;
        logic prev, changed;
        ne = 0; prev = 1'b0; changed = 1'b0;
        for (int i = 0; i < 500 && ne < 4; i++) begin
          @(negedge clk);
          if (c_ilat && !prev) begin
            t[ne] = cyc;
            ne++;
          end
          prev = c_ilat;
          if (ne == 2 && !changed && (cyc - t[1]) == 40) begin
            c_data = 16'h3C5A;
            c_exp.push_back({5'b0, 16'h3C5A});
            changed = 1'b1;
          end
        end
        c_rst_n = 1'b0;
        if (ne < 4) begin
          fail_note("c_frame_wait", "timed out waiting for frames");
        end else begin
          chk("c_period_1", t[1] - t[0], 97);
          chk("c_period_2", t[2] - t[1], 97);
          chk("c_period_3", t[3] - t[2], 97);
        end
        chk("c_frames_seen", c_fcnt, 3);
        chk("c_frames_left", c_exp.size(), 0);
        chk("c_valid_pulses", c_vcnt, 3);
      end
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
